mul_hilo_sequencer: RTL and testbench
=====================================

// Module: mul_hilo_sequencer
// PURPOSE
//  Multi-cycle control stage wrapped around the combinational 32x32 signed bit-pair (radix-4 Booth) multiplier.
//  Registers the operands and drives them to the multiplier, then waits a fixed settle time for the result.
//  Captures the 64-bit product into the HI/LO registers.
//  Writes LO then HI over the datapath's single 32-bit writeback port.
//  Sits between the ALU issue logic (upstream) and the register-file/bus writeback (downstream).
// PARAMETERS
//  SETTLE_CYCLES  2   cycles mul_z is allowed to settle after operands are driven; legal range 1..15
// PORTS
//  clock     in   1   single clock; all state updates on the rising edge
//  clear     in   1   synchronous, active-high reset
//  start     in   1   request a multiply; accepted only in IDLE
//  a         in   32  signed multiplier operand (Q), sampled when start is accepted
//  b         in   32  signed multiplicand operand (M), sampled when start is accepted
//  mul_a     out  32  registered operand driven to the multiplier's a input
//  mul_b     out  32  registered operand driven to the multiplier's b input
//  mul_z     in   64  product returned by the multiplier
//  hi_out    out  32  HI register, product bits [63:32]
//  lo_out    out  32  LO register, product bits [31:0]
//  wb_en     out  1   writeback strobe, one cycle per word
//  wb_sel    out  1   0 = LO word on wb_data, 1 = HI word
//  wb_data   out  32  writeback word
//  busy      out  1   high in every state except IDLE
//  done      out  1   one-cycle completion pulse
// BEHAVIOUR
//  Reset (clear=1 at an edge):
//   - state -> IDLE; counter -> 0.
//   - mul_a, mul_b, hi_out, lo_out, wb_data -> 0.
//   - wb_en, wb_sel, busy, done -> 0.
//   - clear overrides start and aborts any operation in flight; no wb_en is issued afterwards.
//  FSM: IDLE -> DRIVE -> CAPTURE -> WB_LO -> WB_HI -> DONE -> IDLE.
//  IDLE:
//   - start=1 -> mul_a<=a, mul_b<=b, counter<=SETTLE_CYCLES-1, go to DRIVE.
//   - start=0 -> stay in IDLE; mul_a/mul_b hold their values.
//  DRIVE:
//   - counter decrements each cycle; exit to CAPTURE when counter==0.
//   - Stays exactly SETTLE_CYCLES cycles.
//  CAPTURE: {hi_out,lo_out} <= mul_z; mul_z is the two's-complement 64-bit signed product.
//  WB_LO: wb_en=1, wb_sel=0, wb_data=lo_out.
//  WB_HI: wb_en=1, wb_sel=1, wb_data=hi_out.
//  DONE: done=1 for one cycle, then return to IDLE.
//  Output timing and handshake:
//   - wb_en, wb_sel, wb_data and done are registered; they are valid during the named state.
//   - Outside WB_LO/WB_HI: wb_en=0 and wb_data=0.
//   - start is ignored while busy=1, including during DONE. There is no queueing.
//  Latency (start sampled at edge 0):
//   - DRIVE occupies edges 1..SETTLE_CYCLES.
//   - CAPTURE at edge SETTLE_CYCLES+1.
//   - LO written at edge +2, HI at edge +3, done at edge +4.
//   - IDLE again at edge +5. With the default this is 7 cycles start-to-start.
//  Hold: hi_out and lo_out keep the last product until the next CAPTURE.
//  Operand isolation: a and b may change freely after acceptance; only mul_a/mul_b feed the multiplier.
//  Back-to-back: a start held high continuously is re-accepted on the first IDLE cycle after DONE.
// TESTING
//  1. Reset: clear=1 for 2 cycles while start=1 -> all outputs 0, busy=0, no wb_en pulse.
//  2. a=7, b=-3, start pulse -> LO=0xFFFFFFEB then HI=0xFFFFFFFF on wb_data; done at cycle 6.
//  3. a=0x7FFFFFFF, b=0x7FFFFFFF -> HI=0x3FFFFFFF, LO=0x00000001.
//  4. a=b=0x80000000 -> HI=0x40000000, LO=0x00000000.
//  5. start re-pulsed during DRIVE/WB_HI/DONE with other operands -> ignored; results unchanged.
//     Then start held high -> second op accepted exactly one cycle after done.
//  6. clear asserted in WB_LO -> next cycle IDLE, wb_en=0, hi_out=lo_out=0, no HI write.

Source files
------------

// File: rtl/mul_hilo_sequencer.sv
// Multi-cycle control stage around a combinational 32x32 signed multiplier:
// registers the operands, waits for the product to settle, captures HI/LO and writes LO then HI.
module mul_hilo_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_z,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        wb_en,
    output logic        wb_sel,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        CAPTURE,
        WB_LO,
        WB_HI,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_count;
    logic [31:0] r_mulA;
    logic [31:0] r_mulB;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_wbEn;
    logic        r_wbSel;
    logic [31:0] r_wbData;
    logic        r_busy;
    logic        r_done;

    logic        w_wbEnNext;
    logic        w_wbSelNext;
    logic [31:0] w_wbDataNext;
    logic        w_busyNext;
    logic        w_doneNext;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = DRIVE;
            DRIVE:   if (r_count == 4'd0) w_nextState = CAPTURE;
            CAPTURE: w_nextState = WB_LO;
            WB_LO:   w_nextState = WB_HI;
            WB_HI:   w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with the state they belong to.
    // The LO word comes straight from mul_z because r_lo is loaded on the same edge.
    always_comb begin
        w_wbEnNext   = (w_nextState == WB_LO) || (w_nextState == WB_HI);
        w_wbSelNext  = (w_nextState == WB_HI);
        w_wbDataNext = 32'd0;
        if (w_nextState == WB_LO) begin
            w_wbDataNext = mul_z[31:0];
        end else if (w_nextState == WB_HI) begin
            w_wbDataNext = r_hi;
        end
        w_busyNext   = (w_nextState != IDLE);
        w_doneNext   = (w_nextState == DONE);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_count  <= 4'd0;
            r_mulA   <= 32'd0;
            r_mulB   <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_wbEn   <= 1'b0;
            r_wbSel  <= 1'b0;
            r_wbData <= 32'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_mulA  <= a;
                r_mulB  <= b;
                r_count <= 4'(SETTLE_CYCLES - 1);
            end else if (r_state == DRIVE && r_count != 4'd0) begin
                r_count <= r_count - 4'd1;
            end
            if (r_state == CAPTURE) begin
                r_hi <= mul_z[63:32];
                r_lo <= mul_z[31:0];
            end
            r_wbEn   <= w_wbEnNext;
            r_wbSel  <= w_wbSelNext;
            r_wbData <= w_wbDataNext;
            r_busy   <= w_busyNext;
            r_done   <= w_doneNext;
        end
    end

    assign mul_a   = r_mulA;
    assign mul_b   = r_mulB;
    assign hi_out  = r_hi;
    assign lo_out  = r_lo;
    assign wb_en   = r_wbEn;
    assign wb_sel  = r_wbSel;
    assign wb_data = r_wbData;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_mul_hilo_sequencer.sv
// Scoreboard bench for mul_hilo_sequencer; the multiplier model returns garbage until the operands
// have been stable long enough, so an early capture shows up as a wrong product.
module tb_mul_hilo_sequencer;

    localparam int SETTLE = 2;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_z = 64'hBAD0_BAD0_BAD0_BAD0;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        wb_en;
    logic        wb_sel;
    logic [31:0] wb_data;
    logic        busy;
    logic        done;

    typedef struct {
        logic        sel;
        logic [31:0] data;
    } wbExp_t;

    wbExp_t      wbQ[$];
    logic [63:0] doneQ[$];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] prevA = 32'd0;
    logic [31:0] prevB = 32'd0;
    int          settleCnt = 0;

    mul_hilo_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clock  (clock),
        .clear  (clear),
        .start  (start),
        .a      (a),
        .b      (b),
        .mul_a  (mul_a),
        .mul_b  (mul_b),
        .mul_z  (mul_z),
        .hi_out (hi_out),
        .lo_out (lo_out),
        .wb_en  (wb_en),
        .wb_sel (wb_sel),
        .wb_data(wb_data),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Multiplier model: the product only becomes valid SETTLE edges after the operands last moved.
    always @(negedge clock) begin
        if (mul_a !== prevA || mul_b !== prevB) begin
            settleCnt = 0;
            prevA = mul_a;
            prevB = mul_b;
        end else if (settleCnt < 15) begin
            settleCnt++;
        end
        if (settleCnt >= SETTLE)
            mul_z = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
        else
            mul_z = 64'hBAD0_BAD0_BAD0_BAD0;
    end

    always @(negedge clock) begin : monitor
        wbExp_t e;
        logic [63:0] p;
        if (wb_en === 1'b1) begin
            if (wbQ.size() == 0) begin
                checkOutput("unexpected_wb", {63'd0, wb_en}, 64'd0);
            end else begin
                e = wbQ.pop_front();
                checkOutput("wb_sel", {63'd0, wb_sel}, {63'd0, e.sel});
                checkOutput("wb_data", {32'd0, wb_data}, {32'd0, e.data});
            end
        end
        if (done === 1'b1) begin
            if (doneQ.size() == 0) begin
                checkOutput("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                p = doneQ.pop_front();
                checkOutput("hilo_at_done", {hi_out, lo_out}, p);
            end
        end
    end

    task automatic pushExpect(input logic [31:0] hi, input logic [31:0] lo, input bit full);
        wbExp_t e;
        e.sel  = 1'b0;
        e.data = lo;
        wbQ.push_back(e);
        if (full) begin
            e.sel  = 1'b1;
            e.data = hi;
            wbQ.push_back(e);
            doneQ.push_back({hi, lo});
        end
    endtask

    // Issues a one-cycle start pulse; returns at the negedge just before the first DRIVE edge.
    task automatic applyStimulus(input logic [31:0] aIn, input logic [31:0] bIn,
                                 input logic [31:0] hi, input logic [31:0] lo, input bit full);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) checkOutput("idle_timeout", 64'd1, 64'd0);
        pushExpect(hi, lo, full);
        start = 1'b1;
        a = aIn;
        b = bIn;
        @(negedge clock);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic waitDone(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 60) begin
            @(negedge clock);
            cyc++;
        end
        if (cyc >= 60) checkOutput("done_timeout", 64'd1, 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int cyc;
        int n;

        clear = 1'b1;
        start = 1'b1;
        a = 32'h5555_AAAA;
        b = 32'h1234_5678;
        @(negedge clock);
        @(negedge clock);
        checkOutput("reset_operands", {mul_a, mul_b}, 64'd0);
        checkOutput("reset_hilo", {hi_out, lo_out}, 64'd0);
        checkOutput("reset_wb_data", {32'd0, wb_data}, 64'd0);
        checkOutput("reset_flags", {60'd0, wb_en, wb_sel, busy, done}, 64'd0);
        clear = 1'b0;
        start = 1'b0;
        @(negedge clock);
        checkOutput("idle_busy", {63'd0, busy}, 64'd0);

        $display("[TB] 7 * -3 with latency check");
        applyStimulus(32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
        checkOutput("busy_in_drive", {63'd0, busy}, 64'd1);
        waitDone(cyc);
        checkOutput("done_latency", 64'(cyc), 64'd6);
        @(negedge clock);

        applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b1);
        waitDone(cyc);
        @(negedge clock);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1);
        waitDone(cyc);
        @(negedge clock);

        $display("[TB] start ignored while busy");
        applyStimulus(32'h1234_5678, 32'd2, 32'h0000_0000, 32'h2468_ACF0, 1'b1);
        start = 1'b1;
        a = 32'd5;
        b = 32'd5;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(wb_en === 1'b1 && wb_sel === 1'b1) && n < 50) begin
            @(negedge clock);
            n++;
        end
        start = 1'b1;
        a = 32'd9;
        b = 32'd9;
        @(negedge clock);
        checkOutput("done_pulse", {63'd0, done}, 64'd1);
        a = 32'd11;
        @(negedge clock);
        start = 1'b0;
        checkOutput("idle_after_done", {63'd0, busy}, 64'd0);
        @(negedge clock);
        checkOutput("ignored_start_not_latched", {63'd0, busy}, 64'd0);

        $display("[TB] back-to-back with start held");
        pushExpect(32'h3FFF_FFFF, 32'h0000_0001, 1'b1);
        pushExpect(32'h4000_0000, 32'h0000_0000, 1'b1);
        start = 1'b1;
        a = 32'h7FFF_FFFF;
        b = 32'h7FFF_FFFF;
        @(negedge clock);
        a = 32'h8000_0000;
        b = 32'h8000_0000;
        waitDone(cyc);
        @(negedge clock);
        checkOutput("b2b_idle_gap", {63'd0, busy}, 64'd0);
        @(negedge clock);
        checkOutput("b2b_reaccept", {63'd0, busy}, 64'd1);
        start = 1'b0;
        a = 32'd0;
        b = 32'd0;
        waitDone(cyc);
        @(negedge clock);

        applyStimulus(32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1);
        waitDone(cyc);
        @(negedge clock);
        applyStimulus(32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b1);
        waitDone(cyc);
        repeat (3) @(negedge clock);
        checkOutput("hold_hilo", {hi_out, lo_out}, 64'h0000_0001_0000_0000);

        $display("[TB] clear during LO writeback");
        applyStimulus(32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        n = 0;
        while (wb_en !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        checkOutput("clear_wb_en", {63'd0, wb_en}, 64'd0);
        checkOutput("clear_hilo", {hi_out, lo_out}, 64'd0);
        checkOutput("clear_busy", {63'd0, busy}, 64'd0);
        checkOutput("clear_wb_data", {32'd0, wb_data}, 64'd0);
        repeat (8) @(negedge clock);

        checkOutput("queues_drained", 64'(wbQ.size() + doneQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
